// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX/MEM control bundle, bubble constant and
// register-zero index, used by the result, hazard and forwarding blocks.
package pipe_pkg;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } exmem_ctrl_t;

  localparam int unsigned CTRL_W = $bits(exmem_ctrl_t);

  localparam exmem_ctrl_t CTRL_BUBBLE = '0;

  // True when the instruction occupies the data memory port.
  function automatic logic is_mem_access(input exmem_ctrl_t ctrl);
    return ctrl.mem_read | ctrl.mem_write;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: async reset to zero, hold enable, and a
// synchronous clear that loads a zero bubble. Hold has priority over clear.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      if (clear) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/result_pipeline.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory wait handshake:
// a pending access freezes EX/MEM, bubbles MEM/WB and stalls the front end.
module result_pipeline
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ExRegWrite,
  input  logic              ExMemRead,
  input  logic              ExMemWrite,
  input  logic              ExMemToReg,
  input  logic [REG_W-1:0]  ExRegRd,
  input  logic [DATA_W-1:0] ExAluResult,
  input  logic [DATA_W-1:0] ExStoreData,
  input  logic              Flush,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              ExMemRegWrite,
  output logic              ExMemMemRead,
  output logic              ExMemMemWrite,
  output logic [REG_W-1:0]  ExMemRegRd,
  output logic [DATA_W-1:0] ExMemAluResult,
  output logic [DATA_W-1:0] ExMemStoreData,
  output logic              MemWbRegWrite,
  output logic [REG_W-1:0]  MemWbRegRd,
  output logic [DATA_W-1:0] MemWbData,
  output logic              PipeStall,
  output logic [CNT_W-1:0]  StallCycles
);

  localparam int unsigned EXMEM_PAY_W = REG_W + 2 * DATA_W;
  localparam int unsigned MEMWB_CTL_W = 1 + REG_W;

  exmem_ctrl_t             ex_ctrl;
  exmem_ctrl_t             exmem_ctrl;
  logic [EXMEM_PAY_W-1:0]  exmem_pay_d;
  logic [EXMEM_PAY_W-1:0]  exmem_pay_q;
  logic [MEMWB_CTL_W-1:0]  memwb_ctl_d;
  logic [MEMWB_CTL_W-1:0]  memwb_ctl_q;
  logic [DATA_W-1:0]       wb_sel;

  // Writes to $zero are dropped here so forwarding never sees them.
  always_comb begin
    ex_ctrl            = CTRL_BUBBLE;
    ex_ctrl.reg_write  = ExRegWrite && (ExRegRd != REG_W'(REG_ZERO));
    ex_ctrl.mem_read   = ExMemRead;
    ex_ctrl.mem_write  = ExMemWrite;
    ex_ctrl.mem_to_reg = ExMemToReg;
  end

  assign exmem_pay_d = {ExRegRd, ExAluResult, ExStoreData};

  // A flush only kills the control bits; the payload is don't-care in a bubble.
  pipe_stage_reg #(.WIDTH(CTRL_W)) u_exmem_ctrl (
    .clk   (clk),
    .rst   (rst),
    .hold  (PipeStall),
    .clear (Flush),
    .d     (ex_ctrl),
    .q     (exmem_ctrl)
  );

  pipe_stage_reg #(.WIDTH(EXMEM_PAY_W)) u_exmem_pay (
    .clk   (clk),
    .rst   (rst),
    .hold  (PipeStall),
    .clear (1'b0),
    .d     (exmem_pay_d),
    .q     (exmem_pay_q)
  );

  assign ExMemRegWrite = exmem_ctrl.reg_write;
  assign ExMemMemRead  = exmem_ctrl.mem_read;
  assign ExMemMemWrite = exmem_ctrl.mem_write;
  assign {ExMemRegRd, ExMemAluResult, ExMemStoreData} = exmem_pay_q;

  assign PipeStall = is_mem_access(exmem_ctrl) && !MemReady;

  assign memwb_ctl_d = {ExMemRegWrite, ExMemRegRd};
  assign wb_sel      = exmem_ctrl.mem_to_reg ? MemReadData : ExMemAluResult;

  // Each stalled cycle pushes a bubble into MEM/WB while the data value holds.
  pipe_stage_reg #(.WIDTH(MEMWB_CTL_W)) u_memwb_ctl (
    .clk   (clk),
    .rst   (rst),
    .hold  (1'b0),
    .clear (PipeStall),
    .d     (memwb_ctl_d),
    .q     (memwb_ctl_q)
  );

  pipe_stage_reg #(.WIDTH(DATA_W)) u_memwb_data (
    .clk   (clk),
    .rst   (rst),
    .hold  (PipeStall),
    .clear (1'b0),
    .d     (wb_sel),
    .q     (MemWbData)
  );

  assign {MemWbRegWrite, MemWbRegRd} = memwb_ctl_q;

  // Saturating stall-cycle counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCycles <= '0;
    end else if (PipeStall && (StallCycles != {CNT_W{1'b1}})) begin
      StallCycles <= StallCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_result_pipeline.sv
// Scoreboard bench for result_pipeline: an instruction-level model predicts
// EX/MEM contents, stalls and the ordered stream of register write-backs.
module tb_result_pipeline;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, Flush, MemReady;
  logic [RW-1:0] ExRegRd;
  logic [DW-1:0] ExAluResult, ExStoreData, MemReadData;

  logic          em_rw, em_mr, em_mw, wb_rw, stall;
  logic [RW-1:0] em_rd, wb_rd;
  logic [DW-1:0] em_alu, em_sd, wb_data;
  logic [15:0]   cnt16;

  logic          s_em_rw, s_em_mr, s_em_mw, s_wb_rw, s_stall;
  logic [RW-1:0] s_em_rd, s_wb_rd;
  logic [DW-1:0] s_em_alu, s_em_sd, s_wb_data;
  logic [3:0]    cnt4;

  result_pipeline #(.DATA_W(DW), .REG_W(RW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .ExMemToReg(ExMemToReg), .ExRegRd(ExRegRd), .ExAluResult(ExAluResult),
    .ExStoreData(ExStoreData), .Flush(Flush), .MemReady(MemReady),
    .MemReadData(MemReadData),
    .ExMemRegWrite(em_rw), .ExMemMemRead(em_mr), .ExMemMemWrite(em_mw),
    .ExMemRegRd(em_rd), .ExMemAluResult(em_alu), .ExMemStoreData(em_sd),
    .MemWbRegWrite(wb_rw), .MemWbRegRd(wb_rd), .MemWbData(wb_data),
    .PipeStall(stall), .StallCycles(cnt16)
  );

  result_pipeline #(.DATA_W(DW), .REG_W(RW), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .ExMemToReg(ExMemToReg), .ExRegRd(ExRegRd), .ExAluResult(ExAluResult),
    .ExStoreData(ExStoreData), .Flush(Flush), .MemReady(MemReady),
    .MemReadData(MemReadData),
    .ExMemRegWrite(s_em_rw), .ExMemMemRead(s_em_mr), .ExMemMemWrite(s_em_mw),
    .ExMemRegRd(s_em_rd), .ExMemAluResult(s_em_alu), .ExMemStoreData(s_em_sd),
    .MemWbRegWrite(s_wb_rw), .MemWbRegRd(s_wb_rd), .MemWbData(s_wb_data),
    .PipeStall(s_stall), .StallCycles(cnt4)
  );

  typedef struct {
    logic          rw, mr, mw, m2r, flush;
    logic [RW-1:0] rd;
    logic [DW-1:0] alu, sd, ld;
    int            waits;
  } instr_t;

  typedef struct {
    logic          rw, mr, mw, m2r, known;
    logic [RW-1:0] rd;
    logic [DW-1:0] alu, sd, ld;
  } slot_t;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    int            at;
  } wb_t;

  int    checks = 0;
  int    failures = 0;
  int    mon_cyc = 0;
  wb_t   wb_q[$];
  slot_t slot;
  int    waits_left;
  int    exp16, exp4;
  bit    prev_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic rw, input logic mr, input logic mw,
                                input logic [RW-1:0] rd, input logic [DW-1:0] alu,
                                input logic [DW-1:0] sd, input logic [DW-1:0] ld,
                                input int waits, input logic flush);
    instr_t n;
    n.rw = rw; n.mr = mr; n.mw = mw; n.m2r = mr; n.rd = rd;
    n.alu = alu; n.sd = sd; n.ld = ld; n.waits = waits; n.flush = flush;
    return n;
  endfunction

  function automatic instr_t rand_instr();
    int k = $urandom_range(0, 3);
    logic [RW-1:0] rd = RW'($urandom_range(0, 31));
    int w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
    logic fl = ($urandom_range(0, 7) == 0);
    case (k)
      0:       return mk(1'b1, 1'b0, 1'b0, rd, $urandom, $urandom, $urandom, 0, fl);
      1:       return mk(1'b1, 1'b1, 1'b0, rd, $urandom, $urandom, $urandom, w, fl);
      2:       return mk(1'b0, 1'b0, 1'b1, rd, $urandom, $urandom, $urandom, w, fl);
      default: return mk(1'b0, 1'b0, 1'b0, rd, $urandom, $urandom, $urandom, 0, fl);
    endcase
  endfunction

  function automatic instr_t nop();
    return mk(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 0, 1'b0);
  endfunction

  task automatic model_reset();
    slot       = '{default: '0};
    slot.known = 1'b1;
    waits_left = 0;
    exp16      = 0;
    exp4       = 0;
    prev_stall = 1'b0;
    wb_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_em_rw"}, em_rw, 0);      chk({tag, "_em_mr"}, em_mr, 0);
    chk({tag, "_em_mw"}, em_mw, 0);      chk({tag, "_em_rd"}, em_rd, 0);
    chk({tag, "_em_alu"}, em_alu, 0);    chk({tag, "_em_sd"}, em_sd, 0);
    chk({tag, "_wb_rw"}, wb_rw, 0);      chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_wb_data"}, wb_data, 0);  chk({tag, "_stall"}, stall, 0);
    chk({tag, "_cnt16"}, cnt16, 0);      chk({tag, "_cnt4"}, cnt4, 0);
    chk({tag, "_sat_stall"}, s_stall, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, Flush, MemReady} = '0;
    ExRegRd = '0; ExAluResult = '0; ExStoreData = '0; MemReadData = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset("reset");
    rst = 1'b0;
  endtask

  task automatic check_state(input bit stl);
    chk("ex_mem_regwrite", em_rw, slot.rw);
    chk("ex_mem_memread", em_mr, slot.mr);
    chk("ex_mem_memwrite", em_mw, slot.mw);
    if (slot.known) begin
      chk("ex_mem_rd", em_rd, slot.rd);
      chk("ex_mem_alu", em_alu, slot.alu);
      chk("ex_mem_store", em_sd, slot.sd);
    end
    chk("pipe_stall", stall, stl);
    chk("sat_pipe_stall", s_stall, stl);
    chk("stall_cycles", cnt16, exp16);
    chk("sat_stall_cycles", cnt4, exp4);
    if (prev_stall) begin
      chk("mem_wb_bubble_rw", wb_rw, 0);
      chk("mem_wb_bubble_rd", wb_rd, 0);
    end
  endtask

  // One clock of stimulus; the instruction is accepted unless MEM is waiting.
  task automatic step(input instr_t n, output bit accepted);
    bit stl;
    @(negedge clk);
    stl = (slot.mr || slot.mw) && (waits_left > 0);
    ExRegWrite = n.rw; ExMemRead = n.mr; ExMemWrite = n.mw; ExMemToReg = n.m2r;
    ExRegRd = n.rd; ExAluResult = n.alu; ExStoreData = n.sd;
    Flush = stl ? 1'($urandom_range(0, 1)) : n.flush;
    if (stl) begin
      MemReady = 1'b0; MemReadData = $urandom;
    end else if (slot.mr || slot.mw) begin
      MemReady = 1'b1; MemReadData = slot.ld;
    end else begin
      MemReady = 1'($urandom_range(0, 1)); MemReadData = $urandom;
    end
    #1 check_state(stl);
    @(posedge clk);
    prev_stall = stl;
    if (stl) begin
      waits_left--;
      exp16 = (exp16 < 65535) ? exp16 + 1 : exp16;
      exp4  = (exp4 < 15) ? exp4 + 1 : exp4;
      accepted = 1'b0;
    end else begin
      if (slot.rw)
        wb_q.push_back(wb_t'{rd: slot.rd, data: (slot.m2r ? slot.ld : slot.alu), at: mon_cyc + 1});
      if (n.flush) begin
        slot = '{default: '0};
      end else begin
        slot.rw = n.rw && (n.rd != 0); slot.mr = n.mr; slot.mw = n.mw; slot.m2r = n.m2r;
        slot.rd = n.rd; slot.alu = n.alu; slot.sd = n.sd; slot.ld = n.ld; slot.known = 1'b1;
      end
      waits_left = n.waits;
      accepted = 1'b1;
    end
  endtask

  task automatic issue(input instr_t n);
    bit acc = 1'b0;
    while (!acc) step(n, acc);
  endtask

  // Monitor: every write-back the DUT presents must match the next expectation.
  initial begin
    wb_t it;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (rst === 1'b0 && wb_rw === 1'b1) begin
        if (wb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_wb_unexpected actual rd=%0d data=%0h expected none", wb_rd, wb_data);
        end else begin
          it = wb_q.pop_front();
          chk("mem_wb_rd", wb_rd, it.rd);
          chk("mem_wb_data", wb_data, it.data);
          chk("mem_wb_latency", mon_cyc, it.at);
        end
      end
    end
  end

  initial begin
    bit acc;
    do_reset();

    issue(mk(1'b1, 1'b0, 1'b0, 5'd8, 32'h1234, '0, '0, 0, 1'b0));
    issue(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'h5555, '0, '0, 0, 1'b0));
    issue(nop()); issue(nop());

    do_reset();
    issue(mk(1'b1, 1'b1, 1'b0, 5'd9, 32'h100, '0, 32'hCAFE, 3, 1'b0));
    issue(mk(1'b1, 1'b0, 1'b0, 5'd4, 32'h77, '0, '0, 0, 1'b0));
    issue(nop()); issue(nop());
    #1 chk("stall_cycles_after_load", cnt16, 3);

    issue(mk(1'b0, 1'b0, 1'b1, 5'd3, 32'h200, 32'hBEEF, '0, 2, 1'b1));
    issue(mk(1'b0, 1'b0, 1'b1, 5'd3, 32'h204, 32'hF00D, '0, 2, 1'b0));
    issue(mk(1'b1, 1'b0, 1'b0, 5'd6, 32'h66, '0, '0, 0, 1'b1));
    issue(nop()); issue(nop());

    // Reset on the second wait cycle of a load.
    do_reset();
    issue(mk(1'b1, 1'b1, 1'b0, 5'd10, 32'h300, '0, 32'h1111, 5, 1'b0));
    step(nop(), acc);
    @(negedge clk);
    MemReady = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("midstall");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    issue(nop());

    do_reset();
    issue(mk(1'b1, 1'b1, 1'b0, 5'd11, 32'h400, '0, 32'h2222, 20, 1'b0));
    issue(nop()); issue(nop());
    #1 chk("sat_counter_15", cnt4, 15);
    chk("counter16_20", cnt16, 20);

    do_reset();
    for (int i = 0; i < 300; i++) issue(rand_instr());
    repeat (3) issue(nop());
    #1 chk("scoreboard_drained", wb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_pipeline.md
# result_pipeline

Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core. It is the producing end of the operand-forwarding interface: it generates `ExMemRegWrite`, `ExMemRegRd`, `MemWbRegWrite` and `MemWbRegRd` plus the data values the forwarding muxes select. It also owns the data-memory wait handshake:
- On a miss it freezes EX/MEM.
- It injects bubbles into MEM/WB.
- It raises a pipeline-wide stall.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `REG_W`, 5, register-index width
- `CNT_W`, 16, stall-cycle counter width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg`  in  1 each  EX-stage control
- `ExRegRd`  in  REG_W  EX-stage destination register
- `ExAluResult, ExStoreData`  in  DATA_W  EX-stage results
- `Flush`  in  1  replace the instruction entering EX/MEM with a bubble
- `MemReady`  in  1  data memory completes the current access this cycle
- `MemReadData`  in  DATA_W  load data, valid when `MemReady`=1
- `ExMemRegWrite, ExMemMemRead, ExMemMemWrite`  out  1  EX/MEM control
- `ExMemRegRd`  out  REG_W
- `ExMemAluResult, ExMemStoreData`  out  DATA_W  address / forward value; store data
- `MemWbRegWrite`  out  1
- `MemWbRegRd`  out  REG_W
- `MemWbData`  out  DATA_W  selected write-back value
- `PipeStall`  out  1  freeze PC, IF/ID, ID/EX
- `StallCycles`  out  CNT_W  saturating count of stalled cycles

## Operation
- EX/MEM capture when `PipeStall`=0:
  - If `Flush`=1, all EX/MEM control bits load 0 (bubble).
  - Otherwise EX/MEM loads the EX inputs.
  - `ExMemRegWrite` captures `ExRegWrite && ExRegRd!=0`; writes to $zero never become visible to forwarding.
  - `ExMemMemToReg` is an internal flop.
- `PipeStall` is combinational: `(ExMemMemRead || ExMemMemWrite) && !MemReady`.
- While `PipeStall`=1:
  - EX/MEM holds every field. Forwarding from EX/MEM stays valid.
  - `Flush` is ignored. Upstream holds `Flush` until the stall clears.
  - MEM/WB loads a bubble: `MemWbRegWrite`=0, `MemWbRd`=0, `MemWbData` holds.
- MEM/WB capture when `PipeStall`=0:
  - `MemWbRegWrite`/`MemWbRegRd` load from EX/MEM.
  - `MemWbData` loads `MemReadData` if `ExMemMemToReg`, else `ExMemAluResult`.
- Non-memory instructions never stall, regardless of `MemReady`.
- `StallCycles`:
  - +1 on each clock edge with `PipeStall`=1.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.

## Timing
- Reset (async assert, sync-released by the top level):
  - All control outputs are 0.
  - `ExMemRegRd`, `MemWbRegRd` are 0.
  - All data outputs are 0.
  - `StallCycles` is 0.
  - `PipeStall` is 0 (follows, since the EX/MEM mem-ops are 0).
- Latency:
  - EX inputs appear on EX/MEM outputs 1 cycle later.
  - They reach MEM/WB 2 cycles later, plus one cycle per stall cycle.
- A load with `MemReady`=1 in its first MEM cycle adds zero stall.
- A load with N cycles of `MemReady`=0 raises `PipeStall` for exactly N cycles and inserts exactly N MEM/WB bubbles.
- Reset asserted mid-stall clears the held access immediately. There is no pending state.
- `MemReady` may be high with no access; it is ignored.

## Structure
- Shared package `pipe_pkg`:
  - `REG_ZERO` constant.
  - Bubble control constant (all control bits 0).
  - Typedef for the EX/MEM control bundle `{RegWrite, MemRead, MemWrite, MemToReg}`. The hazard and forwarding blocks reuse the same package.
- One natural sub-module: `pipe_stage_reg`, a DATA-parameterised flop with async reset, hold enable and synchronous bubble-clear. It is instantiated for EX/MEM and MEM/WB.
- The counter and the stall logic live in the top module.

## Test plan
- Reset then ALU op:
  - Stimulus: `ExRegWrite`=1, Rd=8, result 0x1234.
  - `ExMemRegRd`=8 and `ExMemAluResult`=0x1234 at cycle+1.
  - `MemWbData`=0x1234 and `MemWbRegWrite`=1 at cycle+2.
- Write to $zero:
  - Stimulus: `ExRegWrite`=1, Rd=0.
  - `ExMemRegWrite`=0 and `MemWbRegWrite`=0.
- Load with 3 wait cycles:
  - Stimulus: `MemReady` low 3 cycles, then high with `MemReadData`=0xCAFE, Rd=9.
  - `PipeStall` high for exactly 3 cycles.
  - EX/MEM is held throughout.
  - 3 MEM/WB bubbles, then `MemWbData`=0xCAFE, Rd=9.
  - `StallCycles`=3.
- Flush:
  - `Flush`=1 with a valid store yields an EX/MEM bubble: `ExMemMemWrite`=0, no stall.
  - `Flush` asserted during a stall leaves EX/MEM unchanged.
- Reset mid-stall:
  - Assert `rst` on the second wait cycle.
  - All outputs are 0 immediately (async), `PipeStall`=0 and `StallCycles`=0.
- Counter saturation:
  - With `CNT_W`=4, hold a load stalled for 20 cycles.
  - `StallCycles` stops at 15.
